// File: rtl/ram_scan_32x4.sv
// 32x4 flop RAM scanned by a free-running address counter: registered read port with
// write-first bypass, wrap detection and a running count of non-zero entries.
module ram_scan_32x4 #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [ADDR_W-1:0] o_rd_addr_q,
    output logic              o_rd_valid,
    output logic              o_frame_done,
    output logic [CNT_W-1:0]  o_nz_count
);

    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic [ADDR_W-1:0] r_rd_addr_q;
    logic              r_rd_valid;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_nz_count;

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_rd_word;
    logic [CNT_W-1:0]  w_nz_d;
    logic              w_frame_d;

    assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < DEPTH_EXT);
    assign w_rd_ok = {1'b0, i_rd_addr} < DEPTH_EXT;

    always_comb begin
        w_old = '0;
        if (w_wr_ok) begin
            w_old = r_mem[i_wr_addr];
        end
    end

    // Write-first: a same-cycle write to the scanned address is returned immediately.
    always_comb begin
        w_rd_word = '0;
        if (w_wr_ok && (i_wr_addr == i_rd_addr)) begin
            w_rd_word = i_wr_data;
        end else if (w_rd_ok) begin
            w_rd_word = r_mem[i_rd_addr];
        end
    end

    // Count moves only on zero <-> non-zero transitions of the written entry.
    always_comb begin
        w_nz_d = r_nz_count;
        if (w_wr_ok) begin
            if ((w_old == '0) && (i_wr_data != '0)) begin
                w_nz_d = r_nz_count + CNT_W'(1);
            end else if ((w_old != '0) && (i_wr_data == '0)) begin
                w_nz_d = r_nz_count - CNT_W'(1);
            end
        end
    end

    assign w_frame_d = r_rd_valid && (r_rd_addr_q == LAST_ADDR) && (i_rd_addr == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data    <= '0;
            r_rd_addr_q  <= '0;
            r_rd_valid   <= 1'b0;
            r_frame_done <= 1'b0;
            r_nz_count   <= '0;
        end else begin
            r_rd_data    <= w_rd_word;
            r_rd_addr_q  <= i_rd_addr;
            r_rd_valid   <= 1'b1;
            r_frame_done <= w_frame_d;
            r_nz_count   <= w_nz_d;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_rd_addr_q  = r_rd_addr_q;
    assign o_rd_valid   = r_rd_valid;
    assign o_frame_done = r_frame_done;
    assign o_nz_count   = r_nz_count;

endmodule

// File: tb/tb_ram_scan_32x4.sv
// Scoreboard bench for ram_scan_32x4: a reference memory model pushes the expected
// registered outputs per edge; each scenario task pops and compares after the edge.
module tb_ram_scan_32x4;

    typedef struct packed {
        logic [3:0] d;
        logic [4:0] a;
        logic       v;
        logic       fd;
        logic [5:0] nz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [4:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic [4:0] rd_addr_q;
    logic       rd_valid;
    logic       frame_done;
    logic [5:0] nz_count;

    logic [3:0] m_mem [32];
    logic       m_valid;
    logic [4:0] m_addr_q;
    exp_t       sb [$];
    exp_t       e;
    int         n_cmp = 0;
    int         n_bad = 0;

    ram_scan_32x4 u_dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_wr_en     (wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_rd_addr   (rd_addr),
        .o_rd_data   (rd_data),
        .o_rd_addr_q (rd_addr_q),
        .o_rd_valid  (rd_valid),
        .o_frame_done(frame_done),
        .o_nz_count  (nz_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = '0;
        m_valid  = 1'b0;
        m_addr_q = '0;
    endtask

    // Drive one cycle at the falling edge, push the expected result, return 1ns after the edge.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [3:0] wd,
                         input logic [4:0] ra);
        exp_t x;
        int   cnt;
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = ra;
        x.d  = (we && wa == ra) ? wd : m_mem[ra];
        x.a  = ra;
        x.v  = 1'b1;
        x.fd = m_valid && (m_addr_q == 5'd31) && (ra == 5'd0);
        if (we) m_mem[wa] = wd;
        cnt = 0;
        for (int i = 0; i < 32; i++) if (m_mem[i] != 4'h0) cnt++;
        x.nz = 6'(cnt);
        m_valid  = 1'b1;
        m_addr_q = ra;
        sb.push_back(x);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_cmp++;
        if ({rd_data, rd_addr_q, rd_valid, frame_done, nz_count} !== 17'd0) begin
            n_bad++;
            $display("FAIL reset_state: got d=%h a=%0d v=%b fd=%b nz=%0d, want all 0",
                     rd_data, rd_addr_q, rd_valid, frame_done, nz_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_scan_empty();
        int fd_seen = 0;
        for (int k = 0; k < 34; k++) begin
            drive(1'b0, 5'd0, 4'h0, 5'(k % 32));
            if (frame_done === 1'b1) fd_seen++;
            e = sb.pop_front();
            n_cmp++;
            if (rd_data !== e.d) begin
                n_bad++;
                $display("FAIL scan_empty_data k=%0d: got %h want %h", k, rd_data, e.d);
            end
            n_cmp++;
            if ({rd_addr_q, rd_valid, frame_done, nz_count} !== {e.a, e.v, e.fd, e.nz}) begin
                n_bad++;
                $display("FAIL scan_empty_status k=%0d: got a=%0d v=%b fd=%b nz=%0d want a=%0d v=%b fd=%b nz=%0d",
                         k, rd_addr_q, rd_valid, frame_done, nz_count, e.a, e.v, e.fd, e.nz);
            end
        end
        n_cmp++;
        if (fd_seen != 1) begin
            n_bad++;
            $display("FAIL scan_empty_wraps: got %0d frame_done pulses want 1", fd_seen);
        end
    endtask

    task automatic test_write_read();
        drive(1'b1, 5'd5, 4'hA, 5'd0);
        drive(1'b0, 5'd0, 4'h0, 5'd5);
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            n_cmp++;
            if ({rd_data, rd_addr_q, nz_count} !== {e.d, e.a, e.nz} && k == 1) begin
                n_bad++;
                $display("FAIL write_read: got d=%h a=%0d nz=%0d want d=%h a=%0d nz=%0d",
                         rd_data, rd_addr_q, nz_count, e.d, e.a, e.nz);
            end
        end
        n_cmp++;
        if ({rd_data, rd_addr_q, nz_count} !== {4'hA, 5'd5, 6'd1}) begin
            n_bad++;
            $display("FAIL write_read_const: got d=%h a=%0d nz=%0d want d=a a=5 nz=1",
                     rd_data, rd_addr_q, nz_count);
        end
    endtask

    task automatic test_collision();
        drive(1'b1, 5'd7, 4'h3, 5'd7);
        e = sb.pop_front();
        n_cmp++;
        if (rd_data !== e.d || rd_data !== 4'h3) begin
            n_bad++;
            $display("FAIL collision: got %h want %h", rd_data, e.d);
        end
        drive(1'b1, 5'd7, 4'h0, 5'd0);
        e = sb.pop_front();
        n_cmp++;
        if (nz_count !== e.nz) begin
            n_bad++;
            $display("FAIL collision_clear_nz: got %0d want %0d", nz_count, e.nz);
        end
    endtask

    task automatic test_nz_count();
        logic [4:0] wa [3] = '{5'd5, 5'd5, 5'd9};
        logic [3:0] wd [3] = '{4'hC, 4'h0, 4'h0};
        logic [5:0] want [3] = '{6'd1, 6'd0, 6'd0};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, wa[k], wd[k], wa[k]);
            e = sb.pop_front();
            n_cmp++;
            if (nz_count !== e.nz || nz_count !== want[k]) begin
                n_bad++;
                $display("FAIL nz_count step %0d: got %0d want %0d", k, nz_count, want[k]);
            end
            n_cmp++;
            if (rd_data !== e.d) begin
                n_bad++;
                $display("FAIL nz_bypass step %0d: got %h want %h", k, rd_data, e.d);
            end
        end
    endtask

    task automatic test_fill_and_reset();
        for (int k = 0; k < 32; k++) begin
            drive(1'b1, 5'(31 - k), 4'hF, 5'(k));
            e = sb.pop_front();
            n_cmp++;
            if ({rd_data, nz_count, frame_done} !== {e.d, e.nz, e.fd}) begin
                n_bad++;
                $display("FAIL fill k=%0d: got d=%h nz=%0d fd=%b want d=%h nz=%0d fd=%b",
                         k, rd_data, nz_count, frame_done, e.d, e.nz, e.fd);
            end
        end
        n_cmp++;
        if (nz_count !== 6'd32) begin
            n_bad++;
            $display("FAIL fill_full: got nz=%0d want 32", nz_count);
        end
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 5'd0, 4'h0, 5'(k));
            e = sb.pop_front();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({rd_data, rd_addr_q, rd_valid, frame_done, nz_count} !== 17'd0) begin
            n_bad++;
            $display("FAIL midscan_reset: got d=%h a=%0d v=%b fd=%b nz=%0d, want all 0",
                     rd_data, rd_addr_q, rd_valid, frame_done, nz_count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 33; k++) begin
            drive(1'b0, 5'd0, 4'h0, 5'(k % 32));
            e = sb.pop_front();
            n_cmp++;
            if ({rd_data, rd_addr_q, rd_valid, frame_done, nz_count} !==
                {e.d, e.a, e.v, e.fd, e.nz} || rd_data !== 4'h0) begin
                n_bad++;
                $display("FAIL post_reset_scan k=%0d: got d=%h a=%0d v=%b fd=%b nz=%0d",
                         k, rd_data, rd_addr_q, rd_valid, frame_done, nz_count);
            end
        end
    endtask

    task automatic test_random_scan();
        logic       we;
        logic [4:0] wa;
        logic [3:0] wd;
        for (int k = 0; k < 96; k++) begin
            we = 1'($urandom_range(0, 1));
            wa = ($urandom_range(0, 3) == 0) ? 5'(k % 32) : 5'($urandom_range(0, 31));
            wd = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            drive(we, wa, wd, 5'(k % 32));
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL random_scan k=%0d: scoreboard empty", k);
            end else begin
                e = sb.pop_front();
                n_cmp++;
                if ({rd_data, rd_addr_q, rd_valid, frame_done, nz_count} !==
                    {e.d, e.a, e.v, e.fd, e.nz}) begin
                    n_bad++;
                    $display("FAIL random_scan k=%0d: got d=%h a=%0d v=%b fd=%b nz=%0d want d=%h a=%0d v=%b fd=%b nz=%0d",
                             k, rd_data, rd_addr_q, rd_valid, frame_done, nz_count,
                             e.d, e.a, e.v, e.fd, e.nz);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_empty();
        test_write_read();
        test_collision();
        test_nz_count();
        test_fill_and_reset();
        test_random_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
